// File: rtl/regfile_read_arbiter_pkg.sv
// regfile_read_arbiter_pkg: FSM state encoding and default widths for the register-file read arbiter
package regfile_arb_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/regfile_read_arbiter_if.sv
// regfile_read_arbiter_if: request, read-port and response signals; slave is the arbiter side
interface regfile_read_arbiter_if import regfile_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) ();
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         rf_sel;
  logic [DATA_W-1:0]         rf_data;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_ready;
  modport slave (input req_valid, req_addr, rf_data, rsp_ready,
                 output req_ready, rf_sel, rsp_valid, rsp_id, rsp_data);
  modport master (output req_valid, req_addr, rf_data, rsp_ready,
                  input req_ready, rf_sel, rsp_valid, rsp_id, rsp_data);
endinterface

// File: rtl/regfile_read_arbiter_picker.sv
// rr_priority_picker: combinational round-robin pick, searching from ptr_i+1 modulo N
module rr_priority_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o
);
  logic         found;
  logic [W-1:0] c;
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    found = 1'b0;
    c = '0;
    for (int i = 1; i <= N; i++) begin
      c = W'((int'(ptr_i) + i) % N);
      if (!found && valid_i[c]) begin
        found = 1'b1;
        grant_o[c] = 1'b1;
        idx_o = c;
      end
    end
  end
endmodule

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: round-robin sharing of one register-file read port among NUM_REQ requesters.
// Optional ZERO_REG_BYPASS_EN answers index-0 reads with zero directly, skipping the mux read.
module regfile_read_arbiter import regfile_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input logic clk,
  input logic reset,
  regfile_read_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
`ifdef ZERO_REG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  state_t             state_q;
  logic [ID_W-1:0]    rr_ptr_q, rsp_id_q, win_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic [ADDR_W-1:0]  rf_sel_q, win_addr;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_valid_q, accept;
  rr_priority_picker #(.N(NUM_REQ), .W(ID_W)) u_pick (
    .valid_i(bus.req_valid),
    .ptr_i  (rr_ptr_q),
    .grant_o(win_gnt),
    .idx_o  (win_idx)
  );
  assign win_addr = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
  assign accept = (state_q == IDLE) && (|bus.req_valid);
  assign bus.req_ready = (state_q == IDLE) ? win_gnt : '0;
  assign bus.rf_sel = rf_sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id = rsp_id_q;
  assign bus.rsp_data = rsp_data_q;
  // rf_sel only moves on a mux-path acceptance so the tree settles for the whole READ cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      rf_sel_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          rsp_id_q <= win_idx;
          rr_ptr_q <= win_idx;
          if (BYPASS && win_addr == '0) begin
            rsp_data_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q <= RESP;
          end else begin
            rf_sel_q <= win_addr;
            state_q <= READ;
          end
        end
        READ: begin
          rsp_data_q <= bus.rf_data;
          rsp_valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb_regfile_read_arbiter: directed and random stimulus against a transaction-level arbiter model
module tb_regfile_read_arbiter;
  localparam int N = 4;
`ifdef ZERO_REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] regs [32];
  int vec = 0;
  int err = 0;
  regfile_read_arbiter_if #(.NUM_REQ(N)) bus ();
  regfile_read_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .reset(reset), .bus(bus));
  assign bus.rf_data = regs[bus.rf_sel];
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // model: last winner, outstanding transaction and the response it will produce
  int m_rr = N - 1;
  bit m_busy, m_reading, m_rsp;
  logic [4:0] m_sel;
  logic [1:0] m_id;
  logic [31:0] m_data;
  int w;
  bit found;
  logic [N-1:0] exp_rdy;
  logic [4:0] a;
  always @(negedge clk) begin
    if (reset) begin
      m_rr = N - 1; m_busy = 0; m_reading = 0; m_rsp = 0;
      m_sel = '0; m_id = '0; m_data = '0;
    end
    found = 0; w = 0;
    if (!m_busy)
      for (int k = 1; k <= N; k++)
        if (!found && bus.req_valid[(m_rr + k) % N]) begin found = 1; w = (m_rr + k) % N; end
    exp_rdy = found ? N'(1 << w) : '0;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    chk("rf_sel", 64'(bus.rf_sel), 64'(m_sel));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_rsp));
    chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
    chk("rsp_data", 64'(bus.rsp_data), 64'(m_data));
    if (!reset) begin
      if (found) begin
        a = bus.req_addr[w*5 +: 5];
        m_busy = 1; m_rr = w; m_id = 2'(w);
        if (BYP && a == 0) begin m_rsp = 1; m_data = '0; end
        else begin m_sel = a; m_reading = 1; end
      end else if (m_reading) begin
        m_reading = 0; m_rsp = 1; m_data = regs[m_sel];
      end else if (m_rsp && bus.rsp_ready) begin
        m_rsp = 0; m_busy = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
  endtask

  task automatic wait_ready(input string nm, input logic [N-1:0] exp);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready != 0) begin got = 1; chk(nm, 64'(bus.req_ready), 64'(exp)); end
    end
    if (!got) chk({nm, "_timeout"}, 64'(0), 64'(exp));
  endtask

  int g[$];
  int t[$];
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[7] = 32'hDEAD_BEEF;
    regs[0] = 32'h1234_5678;
    bus.req_valid = '0; bus.req_addr = '0; bus.rsp_ready = 1'b0;
    cyc(); cyc(); reset = 1'b0;
    // basic read of reg 7 by requester 0
    bus.req_valid = 4'b0001; bus.req_addr = 20'd7; bus.rsp_ready = 1'b1;
    @(negedge clk); chk("t1_ready", 64'(bus.req_ready), 64'h1);
    cyc(); bus.req_valid = '0;
    @(negedge clk); chk("t1_sel", 64'(bus.rf_sel), 64'd7); chk("t1_nvalid", 64'(bus.rsp_valid), 64'd0);
    cyc();
    @(negedge clk); chk("t1_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t1_id", 64'(bus.rsp_id), 64'd0); chk("t1_data", 64'(bus.rsp_data), 64'hDEAD_BEEF);
    // all requesters continuously valid
    do_reset();
    bus.req_valid = 4'b1111; bus.req_addr = {5'd4, 5'd3, 5'd2, 5'd1}; bus.rsp_ready = 1'b1;
    for (int c = 0; c < 20 && g.size() < 5; c++) begin
      @(negedge clk);
      if (bus.req_ready != 0) begin g.push_back(oh2i(bus.req_ready)); t.push_back(c); end
    end
    chk("t2_count", 64'(g.size()), 64'd5);
    for (int k = 0; k < g.size(); k++) begin
      chk("t2_order", 64'(g[k]), 64'(k % N));
      if (k > 0) chk("t2_gap", 64'(t[k] - t[k-1]), 64'd3);
    end
    cyc(); bus.req_valid = '0;
    repeat (4) cyc();
    // response back-pressure
    do_reset();
    bus.req_valid = 4'b0001; bus.req_addr = 20'd7; bus.rsp_ready = 1'b0;
    cyc(); bus.req_valid = 4'b1111;
    cyc(); cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_valid", 64'(bus.rsp_valid), 64'd1); chk("t3_data", 64'(bus.rsp_data), 64'hDEAD_BEEF);
      chk("t3_id", 64'(bus.rsp_id), 64'd0); chk("t3_ready", 64'(bus.req_ready), 64'd0);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); chk("t3_hold", 64'(bus.rsp_valid), 64'd1);
    cyc(); bus.rsp_ready = 1'b0;
    @(negedge clk); chk("t3_rel", 64'(bus.rsp_valid), 64'd0); chk("t3_next", 64'(bus.req_ready), 64'b0010);
    cyc(); bus.req_valid = '0; bus.rsp_ready = 1'b1;
    repeat (4) cyc();
    // reset during READ
    do_reset();
    bus.req_valid = 4'b0001; bus.req_addr = 20'd5;
    @(posedge clk); #2 reset = 1'b1; bus.req_valid = '0;
    #1 chk("t4_sel", 64'(bus.rf_sel), 64'd0); chk("t4_valid", 64'(bus.rsp_valid), 64'd0);
    cyc(); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); chk("t4_norsp", 64'(bus.rsp_valid), 64'd0); end
    cyc(); bus.req_valid = 4'b0101;
    @(negedge clk); chk("t4_first", 64'(bus.req_ready), 64'b0001);
    cyc(); bus.req_valid = '0;
    repeat (4) cyc();
    // zero-register read
    do_reset();
    bus.req_valid = 4'b0001; bus.req_addr = 20'd9; bus.rsp_ready = 1'b1;
    cyc(); bus.req_valid = '0;
    repeat (3) cyc();
    bus.req_valid = 4'b0010; bus.req_addr = 20'd0;
    @(negedge clk); chk("t5_ready", 64'(bus.req_ready), 64'b0010);
    cyc(); bus.req_valid = '0;
    @(negedge clk);
    chk("t5_v1", 64'(bus.rsp_valid), 64'(BYP));
    chk("t5_sel", 64'(bus.rf_sel), BYP ? 64'd9 : 64'd0);
    if (BYP) chk("t5_zero", 64'(bus.rsp_data), 64'd0);
    cyc();
    @(negedge clk);
    if (!BYP) begin
      chk("t5_v2", 64'(bus.rsp_valid), 64'd1);
      chk("t5_data", 64'(bus.rsp_data), 64'h1234_5678); chk("t5_id", 64'(bus.rsp_id), 64'd1);
    end
    repeat (3) cyc();
    // requester 2 withdraws before being granted
    do_reset();
    bus.req_valid = 4'b0001; bus.req_addr = {5'd11, 5'd12, 5'd13, 5'd3};
    cyc(); bus.req_valid = 4'b1110;
    cyc(); bus.req_valid = 4'b1010;
    wait_ready("t6_first", 4'b0010);
    cyc();
    wait_ready("t6_second", 4'b1000);
    cyc(); bus.req_valid = '0;
    repeat (4) cyc();
    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      cyc();
      bus.req_valid = N'($urandom);
      for (int r = 0; r < N; r++) bus.req_addr[r*5 +: 5] = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
      bus.rsp_ready = ($urandom % 3 != 0);
      reset = ($urandom % 150 == 0);
    end
    cyc(); reset = 1'b0;
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
